fpu_exceptions_pipe: RTL and testbench
======================================

Name: fpu_exceptions_pipe

Overview:
Parametrised, handshaked successor to the double-precision exceptions stage. Takes the raw rounded result of the add/sub/mul/div datapath with its operands. Classifies special operands and overrides the result (NaN, infinity, max-finite, signed zero). Produces the five IEEE flags (NV, DZ, OF, UF, NX) per operation and keeps a sticky flag register; sits between the FPU arithmetic core and the writeback/CSR logic.

Parameters:
EXP_BITS, 11, exponent field width (>=2)
MAN_BITS, 52, mantissa field width (>=2); word width W = 1+EXP_BITS+MAN_BITS
PIPE_STAGES, 2, register stages from input to output (1..4)
CANON_NAN, 1, 1 = every NaN result is the canonical qNaN; 0 = propagate quieted input payload

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
op  in  2  00 add, 01 sub, 10 mul, 11 div
rmode  in  2  00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf
opa  in  W  operand A
opb  in  W  operand B
in_except  in  W  raw datapath result
exponent_in  in  EXP_BITS+1  unbiased-overflow exponent from datapath
mantissa_in  in  2  guard/sticky bits
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out  out  W  final result
flags  out  5  {NV,DZ,OF,UF,NX} for this beat
fflags  out  5  sticky OR of flags of all accepted output beats
fflags_clr  in  1  clear sticky flags

Behaviour:
- Reset (rst_n=0 at posedge): all stage valids 0, out=0, flags=0, fflags=0, out_valid=0. Applies mid-operation; in-flight beats are discarded.
- Pipeline: one beat per stage. Stage k advances when empty or stage k+1 advances; last stage advances on out_ready. in_ready = !stage1_valid | stage1 advances (combinational from out_ready allowed). Latency exactly PIPE_STAGES cycles when unstalled; throughput 1/cycle. When out_valid=1 and out_ready=0, out/flags hold stable.
- Classification, with E = all-ones exponent: zero = exp 0 and mantissa 0; inf = E with mantissa 0; qNaN = E with mantissa MSB 1; sNaN = E with mantissa MSB 0 and mantissa nonzero; finite = not inf, not NaN.
- NV: any sNaN; add of opposite-sign infs; sub of same-sign infs; mul 0 x inf (either order); div 0/0; div inf/inf.
- DZ: div, opb zero, opa finite nonzero.
- Result priority: NaN > infinity > underflow zero > in_except.
- NaN result when any NaN input or NV. CANON_NAN=1: {0,E,1,0...}. CANON_NAN=0: opa if NaN, else opb if NaN, with mantissa MSB forced 1; NV without NaN input gives canonical. Flags: NV only.
- Exact infinity: inf operand without NV for add/sub/mul, div inf/finite, or DZ. Output inf, sign = in_except MSB, regardless of rmode; no OF/NX.
- Overflow: all operands finite and exponent_in >= E. Flags OF and NX. Magnitude is inf, except max-finite {E-1, all-ones} when rmode=01, or rmode=10 with negative sign, or rmode=11 with positive sign.
- Underflow: mul/div, both operands finite nonzero (div: opa finite nonzero, opb finite), in_except magnitude 0. Output signed zero from in_except MSB; flags UF, NX.
- Div finite/inf gives exact signed zero, no flags.
- Otherwise out=in_except; NX = |mantissa_in.
- fflags next = (fflags_clr ? 0 : fflags) | (out_valid & out_ready ? flags : 0). A same-cycle clear and accept leaves the new beat's flags set.

Test Plan:
- Default params, mul opa=0x7FF0000000000000 (inf), opb=0 -> out=0x7FF8000000000000, flags=10000, out_valid exactly 2 cycles after accept.
- div opa=0x3FF0000000000000, opb=0x8000000000000000 -> out=0xFFF0000000000000 (in_except sign 1), flags=01000.
- add finite operands, exponent_in=0x800, in_except sign 0, rmode=01 -> out=0x7FEFFFFFFFFFFFFF, flags=00101; rmode=00 -> 0x7FF0000000000000.
- CANON_NAN=0, add opa=0x7FF0000000000001 (sNaN) -> out=0x7FF8000000000001, flags=10000, fflags bit4 set; pulse fflags_clr -> fflags=0.
- EXP_BITS=8, MAN_BITS=23, PIPE_STAGES=3: stream 6 beats with out_ready low cycles 2-4 -> no beat lost/duplicated, order kept, out stable while stalled.
- Assert rst_n=0 with 2 beats in flight -> next cycle out_valid=0, fflags=0, in_ready=1.

Source files
------------

// File: rtl/fpu_exceptions_pipe_if.sv
// Handshaked bus between the FPU arithmetic core, the exceptions stage and writeback/CSR.
// master = core/writeback side driving the stage, slave = the exceptions stage itself.
interface fpu_exceptions_pipe_if #(
    parameter int EXP_BITS = 11,
    parameter int MAN_BITS = 52
);
    localparam int W = 1 + EXP_BITS + MAN_BITS;

    logic                in_valid;
    logic                in_ready;
    logic [1:0]          op;
    logic [1:0]          rmode;
    logic [W-1:0]        opa;
    logic [W-1:0]        opb;
    logic [W-1:0]        in_except;
    logic [EXP_BITS:0]   exponent_in;
    logic [1:0]          mantissa_in;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out;
    logic [4:0]          flags;
    logic [4:0]          fflags;
    logic                fflags_clr;

    modport master (
        output in_valid, op, rmode, opa, opb, in_except, exponent_in, mantissa_in,
               out_ready, fflags_clr,
        input  in_ready, out_valid, out, flags, fflags
    );

    modport slave (
        input  in_valid, op, rmode, opa, opb, in_except, exponent_in, mantissa_in,
               out_ready, fflags_clr,
        output in_ready, out_valid, out, flags, fflags
    );
endinterface

// File: rtl/fpu_exceptions_pipe.sv
// FPU exceptions stage: special-operand classification, result override and IEEE flags,
// computed combinationally at the input and carried through an elastic PIPE_STAGES pipeline.
module fpu_exceptions_pipe #(
    parameter int EXP_BITS    = 11,
    parameter int MAN_BITS    = 52,
    parameter int PIPE_STAGES = 2,
    parameter int CANON_NAN   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fpu_exceptions_pipe_if.slave bus
);
    localparam int W = 1 + EXP_BITS + MAN_BITS;

    localparam logic [EXP_BITS-1:0] EMAX    = '1;
    localparam logic [EXP_BITS-1:0] EMAXM1  = EMAX - 1'b1;
    localparam logic [MAN_BITS-1:0] QBIT    = {1'b1, {(MAN_BITS-1){1'b0}}};
    localparam logic [W-2:0]        INF_MAG = {EMAX, {MAN_BITS{1'b0}}};
    localparam logic [W-2:0]        MAXF_MAG = {EMAXM1, {MAN_BITS{1'b1}}};
    localparam logic [W-1:0]        CNAN    = {1'b0, EMAX, QBIT};
    localparam logic [W-1:0]        QMASK   = {{(EXP_BITS+1){1'b0}}, QBIT};

    localparam logic [4:0] F_NV = 5'b10000;
    localparam logic [4:0] F_DZ = 5'b01000;
    localparam logic [4:0] F_OF = 5'b00100;
    localparam logic [4:0] F_UF = 5'b00010;
    localparam logic [4:0] F_NX = 5'b00001;

    typedef struct packed {
        logic [W-1:0] res;
        logic [4:0]   flg;
    } beat_t;

    // operand classification
    logic [EXP_BITS-1:0] w_ea, w_eb;
    logic [MAN_BITS-1:0] w_ma, w_mb;
    logic w_sa, w_sb, w_sx;
    logic w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_sna, w_snb, w_fa, w_fb;
    logic w_add, w_sub, w_mul, w_div;

    assign w_ea  = bus.opa[W-2:MAN_BITS];
    assign w_eb  = bus.opb[W-2:MAN_BITS];
    assign w_ma  = bus.opa[MAN_BITS-1:0];
    assign w_mb  = bus.opb[MAN_BITS-1:0];
    assign w_sa  = bus.opa[W-1];
    assign w_sb  = bus.opb[W-1];
    assign w_sx  = bus.in_except[W-1];

    assign w_za  = (w_ea == '0) && (w_ma == '0);
    assign w_zb  = (w_eb == '0) && (w_mb == '0);
    assign w_ia  = (w_ea == EMAX) && (w_ma == '0);
    assign w_ib  = (w_eb == EMAX) && (w_mb == '0);
    assign w_na  = (w_ea == EMAX) && (w_ma != '0);
    assign w_nb  = (w_eb == EMAX) && (w_mb != '0);
    assign w_sna = w_na && !w_ma[MAN_BITS-1];
    assign w_snb = w_nb && !w_mb[MAN_BITS-1];
    assign w_fa  = (w_ea != EMAX);
    assign w_fb  = (w_eb != EMAX);

    assign w_add = (bus.op == 2'b00);
    assign w_sub = (bus.op == 2'b01);
    assign w_mul = (bus.op == 2'b10);
    assign w_div = (bus.op == 2'b11);

    // exception conditions
    logic w_nv, w_dz, w_nan, w_xinf, w_ovf, w_maxf, w_dzero, w_unf;

    assign w_nv = w_sna || w_snb
               || (w_add && w_ia && w_ib && (w_sa != w_sb))
               || (w_sub && w_ia && w_ib && (w_sa == w_sb))
               || (w_mul && ((w_za && w_ib) || (w_ia && w_zb)))
               || (w_div && ((w_za && w_zb) || (w_ia && w_ib)));
    assign w_dz    = w_div && w_zb && w_fa && !w_za;
    assign w_nan   = w_na || w_nb || w_nv;
    assign w_xinf  = (!w_div && (w_ia || w_ib)) || (w_div && w_ia) || w_dz;
    assign w_ovf   = w_fa && w_fb && (bus.exponent_in >= {1'b0, EMAX});
    // directed roundings that never reach infinity clamp to the largest finite value
    assign w_maxf  = (bus.rmode == 2'b01)
                  || (bus.rmode == 2'b10 && w_sx)
                  || (bus.rmode == 2'b11 && !w_sx);
    assign w_dzero = w_div && w_fa && w_ib;
    assign w_unf   = (w_mul || w_div) && w_fa && !w_za && w_fb && (w_div || !w_zb)
                  && (bus.in_except[W-2:0] == '0);

    beat_t w_beat;

    always_comb begin
        w_beat.res = bus.in_except;
        w_beat.flg = {4'b0000, |bus.mantissa_in};
        if (w_nan) begin
            w_beat.flg = w_nv ? F_NV : 5'b00000;
            w_beat.res = CNAN;
            if (CANON_NAN == 0 && w_na)
                w_beat.res = bus.opa | QMASK;
            else if (CANON_NAN == 0 && w_nb)
                w_beat.res = bus.opb | QMASK;
        end else if (w_xinf) begin
            w_beat.res = {w_sx, INF_MAG};
            w_beat.flg = w_dz ? F_DZ : 5'b00000;
        end else if (w_ovf) begin
            w_beat.res = {w_sx, (w_maxf ? MAXF_MAG : INF_MAG)};
            w_beat.flg = F_OF | F_NX;
        end else if (w_dzero) begin
            w_beat.res = {w_sx, {(W-1){1'b0}}};
            w_beat.flg = 5'b00000;
        end else if (w_unf) begin
            w_beat.res = {w_sx, {(W-1){1'b0}}};
            w_beat.flg = F_UF | F_NX;
        end
    end

    // elastic pipeline: index 0 is the incoming beat, PIPE_STAGES is the output register
    logic  [PIPE_STAGES:1] r_vld;
    beat_t [PIPE_STAGES:1] r_stg;
    logic  [PIPE_STAGES:0] w_vld;
    beat_t [PIPE_STAGES:0] w_stg;
    logic  [PIPE_STAGES:1] w_adv;
    logic  [4:0]           r_fflags;
    logic                  w_fire;

    assign w_vld  = {r_vld, bus.in_valid};
    assign w_stg  = {r_stg, w_beat};
    assign w_fire = r_vld[PIPE_STAGES] && bus.out_ready;

    always_comb begin
        w_adv = '0;
        w_adv[PIPE_STAGES] = !r_vld[PIPE_STAGES] || bus.out_ready;
        for (int k = PIPE_STAGES - 1; k >= 1; k--)
            w_adv[k] = !r_vld[k] || w_adv[k+1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld    <= '0;
            r_stg    <= '0;
            r_fflags <= '0;
        end else begin
            for (int k = 1; k <= PIPE_STAGES; k++) begin
                if (w_adv[k]) begin
                    r_vld[k] <= w_vld[k-1];
                    if (w_vld[k-1])
                        r_stg[k] <= w_stg[k-1];
                end
            end
            // a clear in the same cycle as an accepted beat keeps that beat's flags
            r_fflags <= (bus.fflags_clr ? 5'b00000 : r_fflags)
                      | (w_fire ? r_stg[PIPE_STAGES].flg : 5'b00000);
        end
    end

    assign bus.in_ready  = w_adv[1];
    assign bus.out_valid = r_vld[PIPE_STAGES];
    assign bus.out       = r_stg[PIPE_STAGES].res;
    assign bus.flags     = r_stg[PIPE_STAGES].flg;
    assign bus.fflags    = r_fflags;
endmodule

// File: tb/tb_fpu_exceptions_pipe.sv
// Bench for fpu_exceptions_pipe: three instances (double/canonical, double/propagate,
// single/3-stage) checked every cycle against a rule-level reference model and scoreboard.
module tb_fpu_exceptions_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fpu_exceptions_pipe_if #(.EXP_BITS(11), .MAN_BITS(52)) b0 ();
    fpu_exceptions_pipe_if #(.EXP_BITS(11), .MAN_BITS(52)) b1 ();
    fpu_exceptions_pipe_if #(.EXP_BITS(8),  .MAN_BITS(23)) b2 ();

    fpu_exceptions_pipe #(.EXP_BITS(11), .MAN_BITS(52), .PIPE_STAGES(2), .CANON_NAN(1))
        u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    fpu_exceptions_pipe #(.EXP_BITS(11), .MAN_BITS(52), .PIPE_STAGES(2), .CANON_NAN(0))
        u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    fpu_exceptions_pipe #(.EXP_BITS(8),  .MAN_BITS(23), .PIPE_STAGES(3), .CANON_NAN(1))
        u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  rm;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] x;
        logic [11:0] ein;
        logic [1:0]  gs;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int acc_cyc = 0;
    logic [68:0] q[3][$];
    logic [4:0]  fmod[3];
    int          npop[3];

    task automatic chk(input string nm, input logic [68:0] got, input logic [68:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference: apply the classification/priority rules directly on field values.
    function automatic logic [68:0] model(input int eb, input int mb, input int canon,
        input logic [1:0] op, input logic [1:0] rm, input logic [63:0] a, input logic [63:0] b,
        input logic [63:0] x, input logic [12:0] ein, input logic [1:0] gs);
        logic [63:0] emax, mmask, qb, sgn, ea, ebx, ma, mbx, res;
        logic [4:0]  fl;
        bit na, nb, ia, ib, za, zb, fa, fb, sa, sb, sx, nv, dz, maxf;
        emax  = (64'd1 << eb) - 64'd1;
        mmask = (64'd1 << mb) - 64'd1;
        qb    = 64'd1 << (mb - 1);
        sgn   = 64'd1 << (eb + mb);
        ea = (a >> mb) & emax;  ebx = (b >> mb) & emax;
        ma = a & mmask;         mbx = b & mmask;
        na = (ea == emax) && (ma != 0);  nb = (ebx == emax) && (mbx != 0);
        ia = (ea == emax) && (ma == 0);  ib = (ebx == emax) && (mbx == 0);
        za = (ea == 0) && (ma == 0);     zb = (ebx == 0) && (mbx == 0);
        fa = (ea != emax);               fb = (ebx != emax);
        sa = (a & sgn) != 0;  sb = (b & sgn) != 0;  sx = (x & sgn) != 0;
        nv = (na && (ma & qb) == 0) || (nb && (mbx & qb) == 0)
          || (op == 0 && ia && ib && sa != sb) || (op == 1 && ia && ib && sa == sb)
          || (op == 2 && ((za && ib) || (ia && zb)))
          || (op == 3 && ((za && zb) || (ia && ib)));
        dz = (op == 3) && zb && fa && !za;
        res = x;
        fl  = {4'b0000, gs != 2'b00};
        if (na || nb || nv) begin
            fl = nv ? 5'b10000 : 5'b00000;
            if (canon == 0 && na)      res = a | qb;
            else if (canon == 0 && nb) res = b | qb;
            else                       res = (emax << mb) | qb;
        end else if ((op != 3 && (ia || ib)) || (op == 3 && ia) || dz) begin
            res = (sx ? sgn : 64'd0) | (emax << mb);
            fl  = dz ? 5'b01000 : 5'b00000;
        end else if (fa && fb && ein >= emax) begin
            maxf = (rm == 1) || (rm == 2 && sx) || (rm == 3 && !sx);
            res  = (sx ? sgn : 64'd0) | (maxf ? (((emax - 1) << mb) | mmask) : (emax << mb));
            fl   = 5'b00101;
        end else if (op == 3 && fa && ib) begin
            res = sx ? sgn : 64'd0;
            fl  = 5'b00000;
        end else if (op >= 2 && fa && !za && fb && (op == 3 || !zb) && (x & (sgn - 1)) == 0) begin
            res = sx ? sgn : 64'd0;
            fl  = 5'b00011;
        end
        return {fl, res};
    endfunction

    task automatic mon(input int id, input logic iv, input logic ir, input logic ov,
                       input logic ordy, input logic clr, input logic [63:0] o,
                       input logic [4:0] fl, input logic [4:0] ff, input logic [68:0] e);
        logic [68:0] h;
        bit          fire;
        if (!rst_n) begin
            q[id].delete();
            fmod[id] = 5'b00000;
            return;
        end
        chk($sformatf("fflags[%0d]", id), {64'd0, ff}, {64'd0, fmod[id]});
        h = '0;
        fire = 0;
        if (ov) begin
            if (q[id].size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL spurious[%0d]: got out_valid=1 expected no pending beat", id);
            end else begin
                h = q[id][0];
                chk($sformatf("out[%0d]", id), {5'd0, o}, {5'd0, h[63:0]});
                chk($sformatf("flags[%0d]", id), {64'd0, fl}, {64'd0, h[68:64]});
                fire = ordy;
            end
        end
        fmod[id] = (clr ? 5'b00000 : fmod[id]) | (fire ? h[68:64] : 5'b00000);
        if (fire) begin
            void'(q[id].pop_front());
            npop[id]++;
        end
        if (iv && ir) q[id].push_back(e);
    endtask

    always @(negedge clk) begin
        mon(0, b0.in_valid, b0.in_ready, b0.out_valid, b0.out_ready, b0.fflags_clr,
            b0.out, b0.flags, b0.fflags,
            model(11, 52, 1, b0.op, b0.rmode, b0.opa, b0.opb, b0.in_except,
                  {1'b0, b0.exponent_in}, b0.mantissa_in));
        mon(1, b1.in_valid, b1.in_ready, b1.out_valid, b1.out_ready, b1.fflags_clr,
            b1.out, b1.flags, b1.fflags,
            model(11, 52, 0, b1.op, b1.rmode, b1.opa, b1.opb, b1.in_except,
                  {1'b0, b1.exponent_in}, b1.mantissa_in));
        mon(2, b2.in_valid, b2.in_ready, b2.out_valid, b2.out_ready, b2.fflags_clr,
            {32'd0, b2.out}, b2.flags, b2.fflags,
            model(8, 23, 1, b2.op, b2.rmode, {32'd0, b2.opa}, {32'd0, b2.opb},
                  {32'd0, b2.in_except}, {4'd0, b2.exponent_in}, b2.mantissa_in));
    end

    task automatic send01(input vec_t v);
        bit ok = 0;
        b0.op = v.op; b0.rmode = v.rm; b0.opa = v.a; b0.opb = v.b; b0.in_except = v.x;
        b0.exponent_in = v.ein; b0.mantissa_in = v.gs; b0.in_valid = 1'b1;
        b1.op = v.op; b1.rmode = v.rm; b1.opa = v.a; b1.opb = v.b; b1.in_except = v.x;
        b1.exponent_in = v.ein; b1.mantissa_in = v.gs; b1.in_valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (b0.in_ready && b1.in_ready) begin ok = 1; acc_cyc = cyc; break; end
        end
        chk("accept01", {68'd0, ok}, 69'd1);
        @(posedge clk); #1;
        b0.in_valid = 1'b0; b1.in_valid = 1'b0;
    endtask

    task automatic send2(input vec_t v);
        bit ok = 0;
        b2.op = v.op; b2.rmode = v.rm; b2.opa = v.a[31:0]; b2.opb = v.b[31:0];
        b2.in_except = v.x[31:0]; b2.exponent_in = v.ein[8:0]; b2.mantissa_in = v.gs;
        b2.in_valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (b2.in_ready) begin ok = 1; break; end
        end
        chk("accept2", {68'd0, ok}, 69'd1);
        @(posedge clk); #1;
        b2.in_valid = 1'b0;
    endtask

    task automatic drain();
        int left;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0) break;
        end
        left = q[0].size() + q[1].size() + q[2].size();
        chk("drain", {37'd0, left}, 69'd0);
        @(posedge clk); #1;
    endtask

    vec_t tv[$];
    vec_t sv[$];
    bit   rnd_on = 0;

    initial begin
        int n0;
        // double-precision directed vectors: op, rmode, opa, opb, in_except, exponent_in, guard/sticky
        tv.push_back('{2'd2, 2'd0, 64'h7FF0000000000000, 64'h0000000000000000, 64'h0, 12'h000, 2'b00});
        tv.push_back('{2'd3, 2'd0, 64'h3FF0000000000000, 64'h8000000000000000, 64'hFFF0000000000000, 12'h000, 2'b00});
        tv.push_back('{2'd0, 2'd1, 64'h7FE0000000000000, 64'h7FE0000000000000, 64'h7FF0000000000000, 12'h800, 2'b00});
        tv.push_back('{2'd0, 2'd0, 64'h7FE0000000000000, 64'h7FE0000000000000, 64'h7FF0000000000000, 12'h800, 2'b00});
        tv.push_back('{2'd0, 2'd0, 64'h7FF0000000000001, 64'h3FF0000000000000, 64'h0123000000000000, 12'h3FF, 2'b00});
        tv.push_back('{2'd2, 2'd0, 64'h3FF0000000000000, 64'h4000000000000000, 64'h4000000000000000, 12'h400, 2'b00});
        tv.push_back('{2'd2, 2'd0, 64'h3FF0000000000000, 64'h4000000000000000, 64'h4000000000000001, 12'h400, 2'b01});
        tv.push_back('{2'd0, 2'd0, 64'h7FF0000000000000, 64'hFFF0000000000000, 64'h0, 12'h000, 2'b00});
        tv.push_back('{2'd1, 2'd0, 64'hFFF0000000000000, 64'hFFF0000000000000, 64'h0, 12'h000, 2'b00});
        tv.push_back('{2'd3, 2'd0, 64'h0000000000000000, 64'h8000000000000000, 64'h0, 12'h000, 2'b00});
        tv.push_back('{2'd3, 2'd0, 64'h7FF0000000000000, 64'h7FF0000000000000, 64'h0, 12'h000, 2'b00});
        tv.push_back('{2'd3, 2'd0, 64'h3FF0000000000000, 64'h7FF0000000000000, 64'h0000000000000123, 12'h000, 2'b10});
        tv.push_back('{2'd2, 2'd0, 64'h8010000000000000, 64'h0010000000000000, 64'h8000000000000000, 12'h000, 2'b11});
        tv.push_back('{2'd0, 2'd0, 64'h3FF0000000000000, 64'hFFF8000000000005, 64'h0, 12'h000, 2'b00});
        tv.push_back('{2'd0, 2'd2, 64'hFFE0000000000000, 64'hFFE0000000000000, 64'hFFF0000000000000, 12'h800, 2'b00});
        tv.push_back('{2'd0, 2'd3, 64'hFFE0000000000000, 64'hFFE0000000000000, 64'hFFF0000000000000, 12'hFFF, 2'b00});
        tv.push_back('{2'd0, 2'd1, 64'h7FF0000000000000, 64'h3FF0000000000000, 64'h7FF0000000000000, 12'h000, 2'b01});
        tv.push_back('{2'd2, 2'd0, 64'h0000000000000000, 64'h3FF0000000000000, 64'h0, 12'h000, 2'b00});
        tv.push_back('{2'd3, 2'd0, 64'h7FF0000000000000, 64'hBFF0000000000000, 64'hFFF0000000000000, 12'h000, 2'b00});
        // single-precision stream
        sv.push_back('{2'd2, 2'd0, 64'h3F800000, 64'h40000000, 64'h40000000, 12'h080, 2'b10});
        sv.push_back('{2'd0, 2'd3, 64'h7F000000, 64'h7F000000, 64'h7F800000, 12'h0FF, 2'b00});
        sv.push_back('{2'd2, 2'd0, 64'h00800000, 64'h80800000, 64'h80000000, 12'h000, 2'b01});
        sv.push_back('{2'd0, 2'd0, 64'h3F800000, 64'h7FC00001, 64'h0, 12'h000, 2'b00});
        sv.push_back('{2'd3, 2'd0, 64'h40000000, 64'h00000000, 64'h7F800000, 12'h000, 2'b00});
        sv.push_back('{2'd2, 2'd0, 64'h7F800000, 64'h00000000, 64'h0, 12'h000, 2'b00});

        // hand-computed values that pin the reference model
        chk("pin_mul_inf_zero", model(11, 52, 1, 2'd2, 2'd0, tv[0].a, tv[0].b, tv[0].x, 13'h0, 2'b00),
            {5'b10000, 64'h7FF8000000000000});
        chk("pin_div_by_zero", model(11, 52, 1, 2'd3, 2'd0, tv[1].a, tv[1].b, tv[1].x, 13'h0, 2'b00),
            {5'b01000, 64'hFFF0000000000000});
        chk("pin_ovf_rtz", model(11, 52, 1, 2'd0, 2'd1, tv[2].a, tv[2].b, tv[2].x, 13'h800, 2'b00),
            {5'b00101, 64'h7FEFFFFFFFFFFFFF});
        chk("pin_ovf_rne", model(11, 52, 1, 2'd0, 2'd0, tv[3].a, tv[3].b, tv[3].x, 13'h800, 2'b00),
            {5'b00101, 64'h7FF0000000000000});
        chk("pin_snan_prop", model(11, 52, 0, 2'd0, 2'd0, tv[4].a, tv[4].b, tv[4].x, 13'h3FF, 2'b00),
            {5'b10000, 64'h7FF8000000000001});
        chk("pin_unf_mul", model(11, 52, 1, 2'd2, 2'd0, tv[12].a, tv[12].b, tv[12].x, 13'h0, 2'b11),
            {5'b00011, 64'h8000000000000000});
        chk("pin_sp_ovf_rdn", model(8, 23, 1, 2'd0, 2'd3, sv[1].a, sv[1].b, sv[1].x, 13'h0FF, 2'b00),
            {5'b00101, 64'h7F7FFFFF});
        chk("pin_sp_qnan", model(8, 23, 1, 2'd0, 2'd0, sv[3].a, sv[3].b, sv[3].x, 13'h0, 2'b00),
            {5'b00000, 64'h7FC00000});

        {b0.in_valid, b0.op, b0.rmode, b0.opa, b0.opb, b0.in_except, b0.exponent_in, b0.mantissa_in} = '0;
        {b1.in_valid, b1.op, b1.rmode, b1.opa, b1.opb, b1.in_except, b1.exponent_in, b1.mantissa_in} = '0;
        {b2.in_valid, b2.op, b2.rmode, b2.opa, b2.opb, b2.in_except, b2.exponent_in, b2.mantissa_in} = '0;
        b0.out_ready = 1'b1; b1.out_ready = 1'b1; b2.out_ready = 1'b1;
        b0.fflags_clr = 1'b0; b1.fflags_clr = 1'b0; b2.fflags_clr = 1'b0;
        for (int i = 0; i < 3; i++) npop[i] = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", {5'd0, b0.out}, 69'd0);
        chk("rst_flags", {64'd0, b0.flags}, 69'd0);
        chk("rst_ovalid", {68'd0, b0.out_valid}, 69'd0);
        chk("rst_fflags", {64'd0, b0.fflags}, 69'd0);
        chk("rst_iready", {68'd0, b0.in_ready}, 69'd1);
        chk("rst_ovalid2", {68'd0, b2.out_valid}, 69'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // latency and first literal result
        send01(tv[0]);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (b0.out_valid) break;
        end
        chk("lat_valid", {68'd0, b0.out_valid}, 69'd1);
        chk("latency", {37'd0, cyc - acc_cyc}, 69'd2);
        chk("lit_out0", {5'd0, b0.out}, {5'd0, 64'h7FF8000000000000});
        chk("lit_flags0", {64'd0, b0.flags}, {64'd0, 5'b10000});
        @(posedge clk); #1;
        drain();

        // full table under irregular back-pressure
        rnd_on = 1;
        fork
            begin
                for (int i = 0; i < tv.size(); i++) send01(tv[i]);
                drain();
                rnd_on = 0;
            end
            begin
                while (rnd_on) begin
                    b0.out_ready = ($urandom_range(0, 3) != 0);
                    b1.out_ready = b0.out_ready;
                    @(posedge clk); #1;
                end
                b0.out_ready = 1'b1; b1.out_ready = 1'b1;
            end
        join
        drain();

        @(negedge clk);
        chk("fflags_nv_sticky", {68'd0, b1.fflags[4]}, 69'd1);
        @(posedge clk); #1;
        b0.fflags_clr = 1'b1; b1.fflags_clr = 1'b1;
        @(posedge clk); #1;
        b0.fflags_clr = 1'b0; b1.fflags_clr = 1'b0;
        @(negedge clk);
        chk("fflags_clr0", {64'd0, b0.fflags}, 69'd0);
        chk("fflags_clr1", {64'd0, b1.fflags}, 69'd0);
        @(posedge clk); #1;

        // clear held across an accepted beat
        b0.fflags_clr = 1'b1; b1.fflags_clr = 1'b1;
        send01(tv[1]);
        drain();
        b0.fflags_clr = 1'b0; b1.fflags_clr = 1'b0;
        send01(tv[6]);
        drain();

        // single-precision stream with out_ready low in cycles 2..4
        n0 = npop[2];
        fork
            begin
                for (int i = 0; i < sv.size(); i++) send2(sv[i]);
            end
            begin
                for (int k = 0; k < 16; k++) begin
                    b2.out_ready = !(k >= 2 && k <= 4);
                    @(posedge clk); #1;
                end
            end
        join
        drain();
        chk("stream_count", {37'd0, npop[2] - n0}, 69'd6);

        // reset with two beats in flight
        @(negedge clk);
        chk("fflags_before_rst", {68'd0, b2.fflags != 5'b0}, 69'd1);
        @(posedge clk); #1;
        send2(sv[0]);
        send2(sv[1]);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ovalid", {68'd0, b2.out_valid}, 69'd0);
        chk("midrst_fflags", {64'd0, b2.fflags}, 69'd0);
        chk("midrst_iready", {68'd0, b2.in_ready}, 69'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
